// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter FSM encoding, CTI codes and a
// helper that sizes the watchdog counter.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Watchdog width: wide enough to hold TIMEOUT, never narrower than 9 bits.
  function automatic int wd_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w > 9) ? w : 9;
  endfunction

endpackage

// File: rtl/wb_sdram_arbiter_if.sv
// One Wishbone B4 point-to-point link, seen from the master or the slave.
interface wb_sdram_arbiter_if #(parameter int ADDRESS = 23);
  logic               cyc, stb, we;
  logic [2:0]         cti;
  logic [1:0]         bte;
  logic [ADDRESS-1:0] adr;
  logic [3:0]         sel;
  logic [31:0]        dat_w;
  logic [31:0]        dat_r;
  logic               ack, rty, err;

  modport master (output cyc, stb, we, cti, bte, adr, sel, dat_w,
                  input  dat_r, ack, rty, err);
  modport slave  (input  cyc, stb, we, cti, bte, adr, sel, dat_w,
                  output dat_r, ack, rty, err);
endinterface

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts consecutive enabled cycles, flags the TIMEOUT-th.
module wb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int WIDTH   = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [WIDTH-1:0] r_cnt;

  // Count stalled cycles; any clear condition restarts from zero.
  always_ff @(posedge clk) begin
    if (rst || clear) r_cnt <= '0;
    else if (enable)  r_cnt <= r_cnt + 1'b1;
  end

  // r_cnt holds the stalls before this one, so TIMEOUT-1 means this cycle
  // is the TIMEOUT-th stalled cycle.
  assign expired = enable && !clear && (r_cnt == WIDTH'(TIMEOUT - 1));
endmodule

// File: rtl/wb_sdram_arbiter.sv
// Two-master Wishbone arbiter in front of one SDRAM controller.
// Grant is held for a whole cycle, a one-cycle GAP separates owners and a
// watchdog aborts a stalled owner with err. Define
// WB_SDRAM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise m0 wins.
module wb_sdram_arbiter
  import wb_pkg::*;
#(
  parameter int ADDRESS = 23,
  parameter int TIMEOUT = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               m0_cyc_i, m0_stb_i, m0_we_i,
  input  logic [2:0]         m0_cti_i,
  input  logic [1:0]         m0_bte_i,
  input  logic [ADDRESS-1:0] m0_adr_i,
  input  logic [3:0]         m0_sel_i,
  input  logic [31:0]        m0_dat_i,
  output logic               m0_ack_o, m0_rty_o, m0_err_o,
  output logic [31:0]        m0_dat_o,
  input  logic               m1_cyc_i, m1_stb_i, m1_we_i,
  input  logic [2:0]         m1_cti_i,
  input  logic [1:0]         m1_bte_i,
  input  logic [ADDRESS-1:0] m1_adr_i,
  input  logic [3:0]         m1_sel_i,
  input  logic [31:0]        m1_dat_i,
  output logic               m1_ack_o, m1_rty_o, m1_err_o,
  output logic [31:0]        m1_dat_o,
  output logic               s_cyc_o, s_stb_o, s_we_o,
  output logic [2:0]         s_cti_o,
  output logic [1:0]         s_bte_o,
  output logic [ADDRESS-1:0] s_adr_o,
  output logic [3:0]         s_sel_o,
  output logic [31:0]        s_dat_o,
  input  logic               s_ack_i, s_rty_i, s_err_i,
  input  logic [31:0]        s_dat_i
);
  localparam int WD_W = wd_width(TIMEOUT);

  arb_state_t r_state, w_next;
  logic w_own0, w_own1, w_cyc_raw, w_stb_raw, w_resp, w_expired, w_pick1;

  // Ownership is masked by reset so a burst in flight is cut off at once.
  assign w_own0    = (r_state == ST_GNT0) && !wb_rst_i;
  assign w_own1    = (r_state == ST_GNT1) && !wb_rst_i;
  assign w_cyc_raw = (w_own0 && m0_cyc_i) || (w_own1 && m1_cyc_i);
  assign w_stb_raw = (w_own0 && m0_stb_i) || (w_own1 && m1_stb_i);
  assign w_resp    = s_ack_i || s_rty_i || s_err_i;

  // Enable uses the un-aborted strobe to avoid a loop through expired.
  wb_watchdog #(.TIMEOUT(TIMEOUT), .WIDTH(WD_W)) u_wd (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (!w_stb_raw || w_resp),
    .enable  (w_stb_raw),
    .expired (w_expired)
  );

`ifdef WB_SDRAM_ARB_ROUND_ROBIN_EN
  logic r_last_m1;

  // Remember the last owner; the reset value lets m0 win the first contest.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_last_m1 <= 1'b1;
    else if ((r_state == ST_GNT0 || r_state == ST_GNT1) && w_next == ST_GAP)
      r_last_m1 <= (r_state == ST_GNT1);
  end

  assign w_pick1 = m1_cyc_i && (!m0_cyc_i || !r_last_m1);
`else
  assign w_pick1 = m1_cyc_i && !m0_cyc_i;
`endif

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next state: grant from IDLE, hold for the owner's cyc, always pass GAP.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (m0_cyc_i || m1_cyc_i) w_next = w_pick1 ? ST_GNT1 : ST_GNT0;
      ST_GNT0: if (!m0_cyc_i || w_expired) w_next = ST_GAP;
      ST_GNT1: if (!m1_cyc_i || w_expired) w_next = ST_GAP;
      ST_GAP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs: mux the owner onto the slave, route responses back to it only.
  always_comb begin
    s_cyc_o  = w_cyc_raw && !w_expired;
    s_stb_o  = w_stb_raw && !w_expired;
    s_we_o   = w_own1 ? m1_we_i  : m0_we_i;
    s_cti_o  = w_own1 ? m1_cti_i : m0_cti_i;
    s_bte_o  = w_own1 ? m1_bte_i : m0_bte_i;
    s_adr_o  = w_own1 ? m1_adr_i : m0_adr_i;
    s_sel_o  = w_own1 ? m1_sel_i : m0_sel_i;
    s_dat_o  = w_own1 ? m1_dat_i : m0_dat_i;
    m0_ack_o = w_own0 && s_ack_i;
    m0_rty_o = w_own0 && s_rty_i;
    m0_err_o = w_own0 && (s_err_i || w_expired);
    m1_ack_o = w_own1 && s_ack_i;
    m1_rty_o = w_own1 && s_rty_i;
    m1_err_o = w_own1 && (s_err_i || w_expired);
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
  end
endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Self-checking bench for wb_sdram_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level model.
module tb_wb_sdram_arbiter;
  import wb_pkg::*;

  localparam int AW = 23;
  localparam int TO = 16;
  localparam logic [AW-1:0] A0 = AW'('h100);
  localparam logic [AW-1:0] A1 = AW'('h200);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_sdram_arbiter_if #(.ADDRESS(AW)) m0i ();
  wb_sdram_arbiter_if #(.ADDRESS(AW)) m1i ();
  wb_sdram_arbiter_if #(.ADDRESS(AW)) si ();

  wb_sdram_arbiter #(.ADDRESS(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i (clk),      .wb_rst_i (rst),
    .m0_cyc_i (m0i.cyc),  .m0_stb_i (m0i.stb),  .m0_we_i  (m0i.we),
    .m0_cti_i (m0i.cti),  .m0_bte_i (m0i.bte),  .m0_adr_i (m0i.adr),
    .m0_sel_i (m0i.sel),  .m0_dat_i (m0i.dat_w),
    .m0_ack_o (m0i.ack),  .m0_rty_o (m0i.rty),  .m0_err_o (m0i.err),
    .m0_dat_o (m0i.dat_r),
    .m1_cyc_i (m1i.cyc),  .m1_stb_i (m1i.stb),  .m1_we_i  (m1i.we),
    .m1_cti_i (m1i.cti),  .m1_bte_i (m1i.bte),  .m1_adr_i (m1i.adr),
    .m1_sel_i (m1i.sel),  .m1_dat_i (m1i.dat_w),
    .m1_ack_o (m1i.ack),  .m1_rty_o (m1i.rty),  .m1_err_o (m1i.err),
    .m1_dat_o (m1i.dat_r),
    .s_cyc_o  (si.cyc),   .s_stb_o  (si.stb),   .s_we_o   (si.we),
    .s_cti_o  (si.cti),   .s_bte_o  (si.bte),   .s_adr_o  (si.adr),
    .s_sel_o  (si.sel),   .s_dat_o  (si.dat_w),
    .s_ack_i  (si.ack),   .s_rty_i  (si.rty),   .s_err_i  (si.err),
    .s_dat_i  (si.dat_r)
  );

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    bit c0, c1;          // master cyc requests from IDLE
    bit ack, rty, err;   // slave responses in the granted cycle
    int own;             // expected owner: 0 none, 1 m0, 2 m1
  } vec_t;
  vec_t vt[7];

  // Randomized-run model state
  int owner, stall, last;
  bit gap;
  bit rc[2], rs[2], rw[2];
  logic [AW-1:0] ra[2];
  logic [3:0]    rsel[2];
  logic [2:0]    rcti[2];
  logic [1:0]    rbte[2];
  logic [31:0]   rd[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_m(input int m, input bit c, input bit s, input bit w,
                         input logic [2:0] cti, input logic [AW-1:0] adr,
                         input logic [31:0] d);
    if (m == 0) begin
      m0i.cyc = c; m0i.stb = s; m0i.we = w; m0i.cti = cti; m0i.bte = 2'b00;
      m0i.adr = adr; m0i.sel = 4'hF; m0i.dat_w = d;
    end else begin
      m1i.cyc = c; m1i.stb = s; m1i.we = w; m1i.cti = cti; m1i.bte = 2'b00;
      m1i.adr = adr; m1i.sel = 4'hF; m1i.dat_w = d;
    end
  endtask

  task automatic idle_all();
    drive_m(0, 0, 0, 0, CTI_CLASSIC, '0, '0);
    drive_m(1, 0, 0, 0, CTI_CLASSIC, '0, '0);
    si.ack = 0; si.rty = 0; si.err = 0;
  endtask

  task automatic do_reset();
    tick(); rst = 1; idle_all();
    tick(); tick(); rst = 0;
  endtask

  task automatic quiesce();
    idle_all();
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int cnt0, cnt1, nbad, n, k, lows, winner, exp_w;
    logic [31:0] dv;
    logic [2:0]  cti_e;

    vt[0] = '{1, 1, 1, 0, 0, 1};
    vt[1] = '{0, 1, 1, 0, 0, 2};
    vt[2] = '{1, 0, 0, 1, 0, 1};
    vt[3] = '{0, 1, 0, 0, 1, 2};
    vt[4] = '{0, 0, 1, 1, 1, 0};
    vt[5] = '{1, 0, 1, 1, 0, 1};
    vt[6] = '{0, 1, 0, 1, 0, 2};

    idle_all(); si.dat_r = '0;
    repeat (3) tick();

    // Reset held with both masters requesting and the slave responding.
    drive_m(0, 1, 1, 0, CTI_CLASSIC, A0, '0);
    drive_m(1, 1, 1, 0, CTI_CLASSIC, A1, '0);
    si.ack = 1; si.rty = 1; si.err = 1;
    settle();
    chk("in_reset_outputs", 64'({si.cyc, si.stb, m0i.ack, m0i.rty, m0i.err,
        m1i.ack, m1i.rty, m1i.err}), 64'(0));

    // Release with both cyc low: everything stays quiet for 5 cycles.
    drive_m(0, 0, 0, 0, CTI_CLASSIC, '0, '0);
    drive_m(1, 0, 0, 0, CTI_CLASSIC, '0, '0);
    tick(); rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); settle();
      chk("post_reset_idle", 64'({si.cyc, si.stb, m0i.ack, m0i.rty, m0i.err,
          m1i.ack, m1i.rty, m1i.err}), 64'(0));
    end

    // Vector table: arbitration from IDLE and response routing.
    do_reset();
    for (int v = 0; v < 7; v++) begin
      drive_m(0, vt[v].c0, vt[v].c0, 0, CTI_CLASSIC, A0, '0);
      drive_m(1, vt[v].c1, vt[v].c1, 0, CTI_CLASSIC, A1, '0);
      tick();
      dv = $urandom;
      si.ack = vt[v].ack; si.rty = vt[v].rty; si.err = vt[v].err; si.dat_r = dv;
      settle();
      chk("vec_scyc", 64'(si.cyc), 64'(vt[v].own != 0));
      if (vt[v].own != 0) chk("vec_adr", 64'(si.adr), 64'((vt[v].own == 1) ? A0 : A1));
      chk("vec_m0_rsp", 64'({m0i.ack, m0i.rty, m0i.err}),
          64'((vt[v].own == 1) ? {vt[v].ack, vt[v].rty, vt[v].err} : 3'b000));
      chk("vec_m1_rsp", 64'({m1i.ack, m1i.rty, m1i.err}),
          64'((vt[v].own == 2) ? {vt[v].ack, vt[v].rty, vt[v].err} : 3'b000));
      chk("vec_rdat", {m0i.dat_r, m1i.dat_r}, {dv, dv});
      idle_all();
      tick(); tick();
    end

    // m0 16-beat INCR write burst to address 0.
    quiesce();
    drive_m(0, 1, 1, 1, CTI_INCR, '0, 32'hA000);
    settle();
    chk("burst_scyc_req_cycle", 64'(si.cyc), 64'(0));
    tick(); settle();
    chk("burst_scyc_next", 64'(si.cyc), 64'(1));
    cnt0 = 0; cnt1 = 0; nbad = 0;
    for (int b = 0; b < 16; b++) begin
      cti_e = (b == 15) ? CTI_EOB : CTI_INCR;
      m0i.cti = cti_e; m0i.adr = AW'(b); m0i.dat_w = 32'hA000 + 32'(b);
      si.ack = 1;
      settle();
      if (m0i.ack) cnt0++;
      if (m1i.ack) cnt1++;
      if (si.cti !== cti_e || si.dat_w !== 32'hA000 + 32'(b) || si.adr !== AW'(b)) nbad++;
      tick();
    end
    idle_all();
    chk("burst_m0_acks", 64'(cnt0), 64'(16));
    chk("burst_m1_acks", 64'(cnt1), 64'(0));
    chk("burst_passthru", 64'(nbad), 64'(0));

    // Contended single reads, 4 rounds; the loser withdraws each round.
    do_reset();
    lows = 0;
    drive_m(0, 1, 1, 0, CTI_CLASSIC, A0, '0);
    drive_m(1, 1, 1, 0, CTI_CLASSIC, A1, '0);
    settle();
    for (int r = 0; r < 4; r++) begin
      k = 0;
      while (!si.cyc && k < 10) begin lows++; tick(); settle(); k++; end
      chk("rr_grant", 64'(si.cyc), 64'(1));
      winner = (si.adr == A0) ? 0 : (si.adr == A1) ? 1 : 9;
`ifdef WB_SDRAM_ARB_ROUND_ROBIN_EN
      exp_w = r % 2;
`else
      exp_w = 0;
`endif
      chk("rr_winner", 64'(winner), 64'(exp_w));
      // drop cycle, GAP and IDLE all show cyc low before the next grant
      if (r > 0) chk("handover_gap", 64'(lows), 64'(3));
      si.ack = 1; settle();
      chk("rr_ack_route", 64'({m0i.ack, m1i.ack}), 64'((exp_w == 0) ? 2'b10 : 2'b01));
      tick(); idle_all(); settle();
      lows = si.cyc ? 0 : 1;
      tick();
      if (r < 3) begin
        drive_m(0, 1, 1, 0, CTI_CLASSIC, A0, '0);
        drive_m(1, 1, 1, 0, CTI_CLASSIC, A1, '0);
      end
      settle();
    end

    // Slave retries for 200 cycles, then acks: grant holds, no err.
    quiesce();
    drive_m(0, 1, 1, 0, CTI_CLASSIC, A0, '0);
    tick();
    si.rty = 1; nbad = 0;
    for (int i = 0; i < 200; i++) begin
      settle();
      if (!si.cyc || !m0i.rty || m0i.err || m1i.rty || si.adr !== A0) nbad++;
      tick();
    end
    si.rty = 0; si.ack = 1; settle();
    chk("rty_hold", 64'(nbad), 64'(0));
    chk("rty_then_ack", 64'({m0i.ack, m0i.err}), 64'(2'b10));

    // Silent slave: watchdog aborts m1 on the TO-th stalled cycle.
    quiesce();
    drive_m(1, 1, 1, 0, CTI_CLASSIC, A1, '0);
    tick(); settle();
    n = 1;
    while (!m1i.err && n < 40) begin tick(); settle(); n++; end
    chk("wd_err_cycle", 64'(n), 64'(TO));
    chk("wd_scyc_drop", 64'({si.cyc, si.stb}), 64'(0));
    chk("wd_m0_quiet", 64'(m0i.err), 64'(0));
    tick(); settle();
    chk("wd_err_one_cycle", 64'(m1i.err), 64'(0));
    drive_m(1, 0, 0, 0, CTI_CLASSIC, '0, '0);
    drive_m(0, 1, 1, 0, CTI_CLASSIC, A0, '0);
    settle();
    chk("wd_gap_low", 64'(si.cyc), 64'(0));
    tick(); settle();
    chk("wd_idle_low", 64'(si.cyc), 64'(0));
    tick(); settle();
    chk("wd_m0_granted", 64'({si.cyc, si.adr}), 64'({1'b1, A0}));

    // Reset on beat 7 of an m1 burst, then a normal m0 grant.
    quiesce();
    drive_m(1, 1, 1, 1, CTI_INCR, A1, 32'h5);
    tick();
    cnt1 = 0;
    for (int b = 1; b <= 6; b++) begin
      si.ack = 1; settle();
      if (m1i.ack) cnt1++;
      tick();
    end
    rst = 1; settle();
    chk("rst_mid_burst_outputs", 64'({si.cyc, si.stb, m1i.ack, m0i.ack}), 64'(0));
    tick(); settle();
    chk("rst_next_scyc", 64'(si.cyc), 64'(0));
    chk("rst_burst_acks", 64'(cnt1), 64'(6));
    rst = 0; idle_all();
    tick();
    drive_m(0, 1, 1, 0, CTI_CLASSIC, A0, '0);
    tick(); settle();
    chk("rst_after_m0_grant", 64'({si.cyc, si.adr}), 64'({1'b1, A0}));
    si.ack = 1; settle();
    chk("rst_after_m0_ack", 64'({m0i.ack, m1i.ack}), 64'(2'b10));

    // Randomized traffic against a transaction-level model.
    do_reset();
    owner = -1; stall = 0; last = 1; gap = 0;
    rc[0] = 0; rc[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      bit quiet, sack, srty, serr, stalled, exp_to, exp_cyc, exp_stb;
      logic [2:0] e0, e1;
      logic [31:0] sdat;
      tick();
      for (int m = 0; m < 2; m++) begin
        if (rc[m]) begin
          if ($urandom_range(0, 7) == 0) rc[m] = 0;
        end else if ($urandom_range(0, 2) == 0) rc[m] = 1;
        rs[m] = rc[m] && ($urandom_range(0, 3) != 0);
        ra[m] = AW'($urandom); rw[m] = 1'($urandom); rsel[m] = 4'($urandom);
        rcti[m] = 3'($urandom); rbte[m] = 2'($urandom); rd[m] = $urandom;
      end
      m0i.cyc = rc[0]; m0i.stb = rs[0]; m0i.we = rw[0]; m0i.adr = ra[0];
      m0i.sel = rsel[0]; m0i.cti = rcti[0]; m0i.bte = rbte[0]; m0i.dat_w = rd[0];
      m1i.cyc = rc[1]; m1i.stb = rs[1]; m1i.we = rw[1]; m1i.adr = ra[1];
      m1i.sel = rsel[1]; m1i.cti = rcti[1]; m1i.bte = rbte[1]; m1i.dat_w = rd[1];
      quiet = (i % 150) >= 120;
      sack = !quiet && ($urandom_range(0, 9) < 4);
      srty = !quiet && ($urandom_range(0, 9) == 0);
      serr = !quiet && ($urandom_range(0, 19) == 0);
      sdat = $urandom;
      si.ack = sack; si.rty = srty; si.err = serr; si.dat_r = sdat;
      settle();

      stalled = (owner >= 0) && rs[owner] && !(sack || srty || serr);
      exp_to  = stalled && (stall + 1 == TO);
      exp_cyc = (owner >= 0) && rc[owner] && !exp_to;
      exp_stb = (owner >= 0) && rs[owner] && !exp_to;
      e0 = (owner == 0) ? {sack, srty, serr || exp_to} : 3'b000;
      e1 = (owner == 1) ? {sack, srty, serr || exp_to} : 3'b000;
      chk("rnd_bus", 64'({si.cyc, si.stb, m0i.ack, m0i.rty, m0i.err,
          m1i.ack, m1i.rty, m1i.err}), 64'({exp_cyc, exp_stb, e0, e1}));
      if (exp_cyc) begin
        chk("rnd_req", 64'({si.adr, si.we, si.sel, si.cti, si.bte}),
            64'({ra[owner], rw[owner], rsel[owner], rcti[owner], rbte[owner]}));
        chk("rnd_wdat", 64'(si.dat_w), 64'(rd[owner]));
      end
      chk("rnd_rdat", {m0i.dat_r, m1i.dat_r}, {sdat, sdat});
      if (n_tot - n_pass > 20) break;

      // Model update for the coming edge.
      stall = (stalled && !exp_to) ? stall + 1 : 0;
      if (gap) gap = 0;
      else if (owner < 0) begin
        if (rc[0] && rc[1]) begin
`ifdef WB_SDRAM_ARB_ROUND_ROBIN_EN
          owner = (last == 0) ? 1 : 0;
`else
          owner = 0;
`endif
        end else if (rc[0]) owner = 0;
        else if (rc[1]) owner = 1;
      end else if (!rc[owner] || exp_to) begin
        last = owner; owner = -1; gap = 1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
